fetch_queue_unit: RTL
=====================

FETCH_QUEUE_UNIT -- requirements
Module: fetch_queue_unit

Interface
REQ-001 Parameter ADDR_W, 32: PC and instruction-memory address width.
REQ-002 Parameter INST_W, 16: instruction width.
REQ-003 Parameter BR_W, 16: branch-target width, sign-extended to ADDR_W.
REQ-004 Parameter RESET_VEC, 50: PC value loaded on reset.
REQ-005 Parameter INT_VEC, 2: PC value loaded on interrupt entry.
REQ-006 Parameter DEPTH, 4: prefetch queue entries, power of two, minimum 2.
REQ-007 clk  in  1: single clock; all state updates on the rising edge.
REQ-008 reset  in  1: synchronous, active-low reset.
REQ-009 branch  in  1: redirect request from a later stage.
REQ-010 branchAdd  in  BR_W: redirect target.
REQ-011 int_req  in  1: interrupt request, level-sampled each cycle.
REQ-012 imem_addr  out  ADDR_W: instruction-memory address; equals PC combinationally.
REQ-013 imem_data  in  INST_W: instruction-memory read data, combinational from imem_addr.
REQ-014 out_valid  out  1: the queue head is presented to decode.
REQ-015 out_ready  in  1: decode accepts the head.
REQ-016 instruction  out  INST_W: queue-head instruction.
REQ-017 pc_out  out  ADDR_W: address of the queue-head instruction.
REQ-018 epc  out  ADDR_W: saved return address of the last interrupt.
REQ-019 int_ack  out  1: one-cycle pulse on interrupt entry.
REQ-020 count  out  log2(DEPTH)+1: current queue occupancy.

Function
REQ-021 Event priority per cycle, highest first: reset, branch, int_req, normal operation.
REQ-022 Push on normal cycles when count != DEPTH (registered value): enqueue {PC, imem_data}, then PC <= PC+1, wrapping modulo 2^ADDR_W.
REQ-023 When count == DEPTH, no push occurs and PC holds, even if a pop happens in the same cycle.
REQ-024 out_valid = (count != 0) and not branch and not int_req-taken; instruction and pc_out show the head entry whenever count != 0.
REQ-025 Pop occurs when out_valid and out_ready are both high; push and pop in one cycle leave count unchanged.
REQ-026 While out_valid is high and out_ready is low, instruction and pc_out hold stable.
REQ-027 On branch: the queue is flushed (count <= 0), PC <= sign-extended branchAdd, and no push or pop occurs.
REQ-028 On int_req without branch: epc <= head pc_out if count != 0, else PC; PC <= INT_VEC; the queue is flushed; int_ack = 1 for the next cycle only.
REQ-029 int_req held high re-enters the interrupt every cycle; the source deasserts it on int_ack.
REQ-030 Redirect latency: a branch or interrupt at edge N produces a push at edge N+1 and out_valid with the target at edge N+1, visible during cycle N+1..N+2.
REQ-031 Queue pointers wrap modulo DEPTH, and occupancy never exceeds DEPTH or goes below 0.

Reset
REQ-032 When reset == 0 at a rising edge: PC <= RESET_VEC, count <= 0, queue pointers <= 0, epc <= 0, int_ack <= 0; out_valid = 0 the following cycle.
REQ-033 Reset mid-operation discards all queued entries and any pending redirect; branch and int_req are ignored in that cycle.
REQ-034 The first push after reset release fetches RESET_VEC at the first edge with reset == 1.

Verification (DEPTH=4, model imem_data = imem_addr[15:0] + 16'h1000)
REQ-035 Release reset, out_ready=1 -> pc_out sequence 50,51,52,... with instruction 0x1032,0x1033,...; one instruction per cycle; count stays at 1.
REQ-036 out_ready=0 for 8 cycles after reset -> count reaches 4, PC holds 54, head stays pc_out=50/0x1032; out_ready=1 -> 50,51,52,53,54 in order, with no gaps and no duplicates.
REQ-037 Queue full, branch=1 with branchAdd=16'hFFF0 -> count=0 next cycle, PC=32'hFFFFFFF0, next valid pc_out=FFFFFFF0; stale entries 50..53 are never handed over.
REQ-038 Queue head pc_out=60 with count=3, int_req=1 for one cycle -> epc=60, int_ack is a one-cycle pulse, next valid pc_out=2; branch and int_req in the same cycle -> branch wins and epc is unchanged.
REQ-039 Assert reset for 1 cycle while count=4 and a branch is pending -> count=0, out_valid=0, next pc_out=50.
REQ-040 Instance with ADDR_W=8, PC started at 8'hFE -> pc_out sequence FE, FF, 00, 01 across the wrap.

Source files
------------

// File: rtl/fetch_queue_unit.sv
// Instruction fetch unit: PC sequencing with branch/interrupt redirect feeding a
// DEPTH-entry prefetch queue that hands {pc, instruction} pairs to decode.
module fetch_queue_unit #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned INST_W    = 16,
    parameter int unsigned BR_W      = 16,
    parameter int unsigned RESET_VEC = 50,
    parameter int unsigned INT_VEC   = 2,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     branch,
    input  logic [BR_W-1:0]          branchAdd,
    input  logic                     int_req,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic [INST_W-1:0]        imem_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INST_W-1:0]        instruction,
    output logic [ADDR_W-1:0]        pc_out,
    output logic [ADDR_W-1:0]        epc,
    output logic                     int_ack,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    entry_t             queue_q [DEPTH];
    logic [ADDR_W-1:0]  pc_q, pc_n;
    logic [ADDR_W-1:0]  epc_q, epc_n;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_n;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_n;
    logic [CNT_W-1:0]   count_q, count_n;
    logic               int_ack_q, int_ack_n;
    logic               full;
    logic               push;
    logic               pop;
    entry_t             head;

    // Redirect cycles neither push nor present; fullness uses the registered count.
    always_comb begin
        full      = (count_q == CNT_W'(DEPTH));
        head      = queue_q[rd_ptr_q];
        out_valid = (count_q != '0) && !branch && !int_req;
        push      = !branch && !int_req && !full;
        pop       = out_valid && out_ready;
    end

    // Next-state: branch beats interrupt beats normal fetch.
    always_comb begin
        pc_n      = pc_q;
        epc_n     = epc_q;
        wr_ptr_n  = wr_ptr_q;
        rd_ptr_n  = rd_ptr_q;
        count_n   = count_q;
        int_ack_n = 1'b0;
        if (branch) begin
            pc_n     = ADDR_W'($signed(branchAdd));
            wr_ptr_n = '0;
            rd_ptr_n = '0;
            count_n  = '0;
        end else if (int_req) begin
            epc_n     = (count_q != '0) ? head.pc : pc_q;
            pc_n      = ADDR_W'(INT_VEC);
            wr_ptr_n  = '0;
            rd_ptr_n  = '0;
            count_n   = '0;
            int_ack_n = 1'b1;
        end else begin
            if (push) begin
                wr_ptr_n = wr_ptr_q + PTR_W'(1);
                pc_n     = pc_q + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr_n = rd_ptr_q + PTR_W'(1);
            end
            count_n = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q      <= ADDR_W'(RESET_VEC);
            epc_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            int_ack_q <= 1'b0;
        end else begin
            pc_q      <= pc_n;
            epc_q     <= epc_n;
            wr_ptr_q  <= wr_ptr_n;
            rd_ptr_q  <= rd_ptr_n;
            count_q   <= count_n;
            int_ack_q <= int_ack_n;
        end
    end

    // Queue storage needs no reset; occupancy alone marks entries live.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            queue_q[wr_ptr_q] <= '{pc: pc_q, inst: imem_data};
        end
    end

    assign imem_addr   = pc_q;
    assign instruction = head.inst;
    assign pc_out      = head.pc;
    assign epc         = epc_q;
    assign int_ack     = int_ack_q;
    assign count       = count_q;

endmodule
